trap_csr_unit: RTL and testbench
================================

TRAP_CSR_UNIT -- requirements
Module: trap_csr_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: csr_op_i  in  3  000 none, 001 RW, 010 RS (set), 011 RC (clear), others none.
REQ-004 SHALL have ports: csr_addr_i  in  12  CSR address.
REQ-005 SHALL have ports: csr_wd_i  in  32  write operand (rs1/imm).
REQ-006 SHALL have ports: pc_i  in  32  PC of instruction in execute.
REQ-007 SHALL have ports: irq_i  in  1  interrupt pending, from interrupt controller INT_o.
REQ-008 SHALL have ports: irq_cause_i  in  32  cause code, from interrupt controller mcause_o.
REQ-009 SHALL have ports: mret_i  in  1  mret decoded in execute.
REQ-010 SHALL have ports: csr_rd_o  out  32  CSR read data; mie_o  out  32  to controller mie_i; mtvec_o  out  32  trap target; mepc_o  out  32  return target.
REQ-011 SHALL have ports: trap_o  out  1  redirect PC to mtvec_o this cycle; irq_ret_o  out  1  to controller INT_RST_i.

Function
REQ-012 SHALL implement mstatus 0x300 (bit3 MIE, bit7 MPIE, other bits read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342; all 32-bit.
REQ-013 SHALL drive csr_rd_o combinationally with the pre-write value of the addressed CSR; unmapped address -> 0, write ignored.
REQ-014 SHALL update the addressed CSR at the clock edge: RW new=wd, RS new=old|wd, RC new=old&~wd; mepc bits[1:0] forced 0, mtvec bits[1:0] forced 0.
REQ-015 SHALL run FSM IDLE -> TRAP_ACTIVE -> RETURN -> IDLE.
REQ-016 IDLE: irq_i=1 and MIE=1 -> trap_o=1 combinationally; at edge mepc<=pc_i, mcause<={1'b1, irq_cause_i[30:0]}, MPIE<=MIE, MIE<=0, state TRAP_ACTIVE.
REQ-017 TRAP_ACTIVE: irq_i ignored; mret_i=1 -> MIE<=MPIE, MPIE<=1, state RETURN.
REQ-018 RETURN: irq_ret_o=1 for exactly this one cycle; irq_i ignored; next state IDLE.
REQ-019 Simultaneous trap acceptance and CSR op SHALL suppress the CSR write (instruction re-executes from mepc).
REQ-020 mret_i in IDLE or RETURN SHALL be ignored (no state change, no irq_ret_o).
REQ-021 CSR ops in TRAP_ACTIVE SHALL execute normally; a software write to mcause/mepc SHALL take effect.
REQ-022 trap_o SHALL be 0 in TRAP_ACTIVE and RETURN; mie_o, mtvec_o, mepc_o SHALL mirror registers continuously.

Reset
REQ-023 rst_i=1 SHALL asynchronously clear all CSRs to 0, state to IDLE, irq_ret_o to 0, trap_o to 0, including mid-trap or mid-RETURN.
REQ-024 First edge after rst_i release SHALL behave as IDLE with interrupts disabled (MIE=0).

Structure
REQ-025 Package csr_pkg SHALL hold CSR address constants, csr_op enum, FSM state enum, MIE/MPIE bit positions.
REQ-026 Sub-module csr_wdata_calc SHALL compute the RW/RS/RC new value; all state SHALL live in trap_csr_unit.

Verification
REQ-027 Reset then read 0x300, 0x304, 0x305 -> csr_rd_o=0 each; trap_o=0 with irq_i=1.
REQ-028 RW 0x305<=0x0000_0103, RS 0x300<=0x8, RW 0x304<=0x1; irq_i=1, cause=5, pc_i=0x40 -> trap_o=1 that cycle; mtvec_o=0x100, mepc_o=0x40, mcause=0x8000_0005, mstatus=0x80.
REQ-029 From TRAP_ACTIVE, mret_i=1 -> next cycle irq_ret_o=1 for one cycle, mstatus=0x88; next cycle IDLE, irq_ret_o=0.
REQ-030 irq_i=1, MIE=1, concurrent RW 0x340<=0xDEAD_BEEF -> trap taken, mscratch unchanged (0).
REQ-031 RC 0x304 with wd=0xFFFF_FFFF after mie=0x3 -> csr_rd_o=0x3, mie_o=0; read 0x7C0 -> 0.
REQ-032 rst_i asserted mid-TRAP_ACTIVE between edges -> all outputs 0 immediately, mret_i afterwards gives no irq_ret_o.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode trap/CSR unit.
//   CSR addresses of the implemented registers, the csr_op encoding, the
//   trap FSM state encoding and the mstatus MIE/MPIE bit positions.
package csr_pkg;

  // Implemented machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // Only these two mstatus bits exist; every other bit reads as zero
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Codes 100..111 are treated like NONE
  typedef enum logic [2:0] {
    CSR_OP_NONE = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_TRAP_ACTIVE = 2'd1,
    ST_RETURN      = 2'd2
  } trap_state_e;

  // Builds the architectural mstatus view from the two stored bits
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = '0;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/trap_csr_unit_if.sv
// Bus between the execute stage / interrupt controller and the trap CSR unit.
//   master : execute-side driver (CSR op, address, operand, pc, irq, mret)
//   slave  : the trap CSR unit (read data, mirrored CSRs, trap and return pulses)
interface trap_csr_unit_if;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wd_i;
  logic [31:0] pc_i;
  logic        irq_i;
  logic [31:0] irq_cause_i;
  logic        mret_i;
  logic [31:0] csr_rd_o;
  logic [31:0] mie_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        trap_o;
  logic        irq_ret_o;

  modport master (
    output csr_op_i, csr_addr_i, csr_wd_i, pc_i, irq_i, irq_cause_i, mret_i,
    input  csr_rd_o, mie_o, mtvec_o, mepc_o, trap_o, irq_ret_o
  );

  modport slave (
    input  csr_op_i, csr_addr_i, csr_wd_i, pc_i, irq_i, irq_cause_i, mret_i,
    output csr_rd_o, mie_o, mtvec_o, mepc_o, trap_o, irq_ret_o
  );
endinterface

// File: rtl/csr_wdata_calc.sv
// Computes the value a CSR instruction would write.
//   op_i  : csr_op code (RW / RS / RC, anything else is no write)
//   old_i : current value of the addressed CSR
//   wd_i  : instruction operand (rs1 or immediate)
//   new_o : value to store
//   we_o  : op is a writing op
module csr_wdata_calc
  import csr_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wd_i,
  output logic [31:0] new_o,
  output logic        we_o
);

  // Pure combinational read-modify-write; non-writing codes pass old through
  always_comb begin
    new_o = old_i;
    we_o  = 1'b0;
    case (op_i)
      CSR_OP_RW: begin
        new_o = wd_i;
        we_o  = 1'b1;
      end
      CSR_OP_RS: begin
        new_o = old_i | wd_i;
        we_o  = 1'b1;
      end
      CSR_OP_RC: begin
        new_o = old_i & ~wd_i;
        we_o  = 1'b1;
      end
      default: begin
        new_o = old_i;
        we_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file with interrupt trap entry / mret return sequencing.
//   clk   : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : slave side of trap_csr_unit_if
//           inputs  csr_op_i, csr_addr_i, csr_wd_i, pc_i, irq_i, irq_cause_i, mret_i
//           outputs csr_rd_o (pre-write value), mie_o, mtvec_o, mepc_o,
//                   trap_o (combinational redirect), irq_ret_o (one-cycle ack)
module trap_csr_unit
  import csr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_i,
  trap_csr_unit_if.slave bus
);

  trap_state_e state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        irq_ret_q, irq_ret_d;

  logic [31:0] csr_rd;
  logic        csr_hit;
  logic [31:0] csr_new;
  logic        op_we;
  logic        csr_we;
  logic        trap_take;

  // Read mux: always shows the value held before this cycle's write.
  // Unmapped addresses read zero and are flagged so the write is dropped.
  always_comb begin
    csr_rd  = '0;
    csr_hit = 1'b1;
    case (bus.csr_addr_i)
      CSR_MSTATUS:  csr_rd = mstatus_pack(mstatus_mie_q, mstatus_mpie_q);
      CSR_MIE:      csr_rd = mie_q;
      CSR_MTVEC:    csr_rd = mtvec_q;
      CSR_MSCRATCH: csr_rd = mscratch_q;
      CSR_MEPC:     csr_rd = mepc_q;
      CSR_MCAUSE:   csr_rd = mcause_q;
      default: begin
        csr_rd  = '0;
        csr_hit = 1'b0;
      end
    endcase
  end

  csr_wdata_calc u_wdata_calc (
    .op_i  (bus.csr_op_i),
    .old_i (csr_rd),
    .wd_i  (bus.csr_wd_i),
    .new_o (csr_new),
    .we_o  (op_we)
  );

  // A trap is only accepted from IDLE; the interrupted instruction will be
  // re-executed from mepc, so its CSR write must not land now.
  assign trap_take = (state_q == ST_IDLE) && bus.irq_i && mstatus_mie_q;
  assign csr_we    = op_we && csr_hit && !trap_take;

  // Next-state logic: software CSR write first, then trap entry or mret
  // override the mstatus bits (mret restores from the pre-cycle MPIE).
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    irq_ret_d      = 1'b0;

    if (csr_we) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_new[MSTATUS_MIE_BIT];
          mstatus_mpie_d = csr_new[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = csr_new;
        CSR_MTVEC:    mtvec_d    = csr_new & ~32'h3;
        CSR_MSCRATCH: mscratch_d = csr_new;
        CSR_MEPC:     mepc_d     = csr_new & ~32'h3;
        CSR_MCAUSE:   mcause_d   = csr_new;
        default:      mie_d      = mie_q;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (trap_take) begin
          mepc_d         = bus.pc_i & ~32'h3;
          mcause_d       = bus.irq_cause_i | 32'h8000_0000;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
          state_d        = ST_TRAP_ACTIVE;
        end
      end
      ST_TRAP_ACTIVE: begin
        if (bus.mret_i) begin
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
          irq_ret_d      = 1'b1;
          state_d        = ST_RETURN;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All architectural state; reset clears everything immediately, even in
  // the middle of a trap or return sequence.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      irq_ret_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      irq_ret_q      <= irq_ret_d;
    end
  end

  assign bus.csr_rd_o  = csr_rd;
  assign bus.trap_o    = trap_take;
  assign bus.irq_ret_o = irq_ret_q;
  assign bus.mie_o     = mie_q;
  assign bus.mtvec_o   = mtvec_q;
  assign bus.mepc_o    = mepc_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Scoreboard bench for trap_csr_unit: stimulus pushes expected outputs from a
// behavioural model, a separate monitor pops and compares every cycle.
module tb_trap_csr_unit;

  logic clk;
  logic rst_i;

  trap_csr_unit_if bus_if ();

  trap_csr_unit dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] rd;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        trap;
    logic        irq_ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of the architectural state
  bit          m_mie_en;
  bit          m_mpie;
  logic [31:0] m_mie;
  logic [31:0] m_mtvec;
  logic [31:0] m_mscratch;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  bit          m_in_handler;
  bit          m_returning;

  function automatic void modelReset();
    m_mie_en     = 0;
    m_mpie       = 0;
    m_mie        = '0;
    m_mtvec      = '0;
    m_mscratch   = '0;
    m_mepc       = '0;
    m_mcause     = '0;
    m_in_handler = 0;
    m_returning  = 0;
  endfunction

  function automatic bit modelMapped(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h304) || (a == 12'h305) ||
           (a == 12'h340) || (a == 12'h341) || (a == 12'h342);
  endfunction

  function automatic logic [31:0] modelRead(input logic [11:0] a);
    case (a)
      12'h300: return (m_mie_en ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit modelTrap(input logic irq);
    return !m_in_handler && !m_returning && irq && m_mie_en;
  endfunction

  // Advances the model across one clock edge
  function automatic void modelStep(input logic [2:0] op, input logic [11:0] addr,
                                    input logic [31:0] wd, input logic [31:0] pc,
                                    input logic irq, input logic [31:0] cause,
                                    input logic mret);
    logic [31:0] old;
    logic [31:0] nv;
    bit          old_mpie;
    old      = modelRead(addr);
    old_mpie = m_mpie;
    if (modelTrap(irq)) begin
      m_mepc       = {pc[31:2], 2'b00};
      m_mcause     = {1'b1, cause[30:0]};
      m_mpie       = m_mie_en;
      m_mie_en     = 0;
      m_in_handler = 1;
    end else begin
      if (op >= 3'd1 && op <= 3'd3 && modelMapped(addr)) begin
        if (op == 3'd1)      nv = wd;
        else if (op == 3'd2) nv = old | wd;
        else                 nv = old & ~wd;
        case (addr)
          12'h300: begin
            m_mie_en = nv[3];
            m_mpie   = nv[7];
          end
          12'h304: m_mie      = nv;
          12'h305: m_mtvec    = {nv[31:2], 2'b00};
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = {nv[31:2], 2'b00};
          default: m_mcause   = nv;
        endcase
      end
      if (m_in_handler && mret) begin
        m_mie_en     = old_mpie;
        m_mpie       = 1;
        m_in_handler = 0;
        m_returning  = 1;
      end else if (m_returning) begin
        m_returning = 0;
      end
    end
  endfunction

  // Drives one cycle of inputs after the falling edge and queues what the
  // DUT should show before the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [2:0] op,
                               input logic [11:0] addr, input logic [31:0] wd,
                               input logic [31:0] pc, input logic irq,
                               input logic [31:0] cause, input logic mret);
    exp_t e;
    @(negedge clk);
    #1;
    rst_i              = rst;
    bus_if.csr_op_i    = op;
    bus_if.csr_addr_i  = addr;
    bus_if.csr_wd_i    = wd;
    bus_if.pc_i        = pc;
    bus_if.irq_i       = irq;
    bus_if.irq_cause_i = cause;
    bus_if.mret_i      = mret;
    if (rst) modelReset();
    e.rd      = modelRead(addr);
    e.mie     = m_mie;
    e.mtvec   = m_mtvec;
    e.mepc    = m_mepc;
    e.trap    = modelTrap(irq);
    e.irq_ret = m_returning;
    sb_q.push_back(e);
    if (!rst) modelStep(op, addr, wd, pc, irq, cause, mret);
  endtask

  task automatic compareField(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("csr_rd_o",  bus_if.csr_rd_o,          e.rd);
    compareField("mie_o",     bus_if.mie_o,             e.mie);
    compareField("mtvec_o",   bus_if.mtvec_o,           e.mtvec);
    compareField("mepc_o",    bus_if.mepc_o,            e.mepc);
    compareField("trap_o",    {31'b0, bus_if.trap_o},    {31'b0, e.trap});
    compareField("irq_ret_o", {31'b0, bus_if.irq_ret_o}, {31'b0, e.irq_ret});
  endtask

  // Monitor: outputs are presented every cycle, sampled mid low phase
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  logic [11:0] addr_pool [9];

  initial begin
    logic [11:0] a;
    addr_pool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'h7C0, 12'h001, 12'h301};
    rst_i              = 1'b1;
    bus_if.csr_op_i    = '0;
    bus_if.csr_addr_i  = '0;
    bus_if.csr_wd_i    = '0;
    bus_if.pc_i        = '0;
    bus_if.irq_i       = 1'b0;
    bus_if.irq_cause_i = '0;
    bus_if.mret_i      = 1'b0;
    modelReset();

    $display("[TB] reset and post-reset reads");
    applyStimulus(1, 3'd0, 12'h300, 0, 0, 1, 0, 0);
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 1, 5, 0);
    applyStimulus(0, 3'd0, 12'h304, 0, 0, 1, 5, 0);
    applyStimulus(0, 3'd0, 12'h305, 0, 0, 0, 0, 0);

    $display("[TB] configure and take interrupt");
    applyStimulus(0, 3'd1, 12'h305, 32'h0000_0103, 0, 0, 0, 0);
    applyStimulus(0, 3'd2, 12'h300, 32'h8, 0, 0, 0, 0);
    applyStimulus(0, 3'd1, 12'h304, 32'h1, 0, 0, 0, 0);
    applyStimulus(0, 3'd0, 12'h342, 0, 32'h40, 1, 5, 0);
    applyStimulus(0, 3'd0, 12'h342, 0, 32'h80, 1, 7, 0);
    applyStimulus(0, 3'd0, 12'h300, 0, 32'h80, 1, 7, 0);

    $display("[TB] mret and return");
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 0, 0, 1);
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 1, 3, 1);
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 0, 0, 1);

    $display("[TB] trap with concurrent CSR write");
    applyStimulus(0, 3'd1, 12'h340, 32'hDEAD_BEEF, 32'h124, 1, 9, 0);
    applyStimulus(0, 3'd0, 12'h340, 0, 0, 0, 0, 0);
    applyStimulus(0, 3'd0, 12'h341, 0, 0, 0, 0, 1);
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 0, 0, 0);

    $display("[TB] clear mie and unmapped read");
    applyStimulus(0, 3'd1, 12'h304, 32'h3, 0, 0, 0, 0);
    applyStimulus(0, 3'd3, 12'h304, 32'hFFFF_FFFF, 0, 0, 0, 0);
    applyStimulus(0, 3'd1, 12'h7C0, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(0, 3'd0, 12'h7C0, 0, 0, 0, 0, 0);

    $display("[TB] reset in the middle of a trap");
    applyStimulus(0, 3'd1, 12'h305, 32'h200, 0, 0, 0, 0);
    applyStimulus(0, 3'd0, 12'h341, 0, 32'h88, 1, 2, 0);
    applyStimulus(1, 3'd0, 12'h305, 0, 0, 1, 2, 0);
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 1, 2, 1);
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 0, 0, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      a = addr_pool[$urandom_range(0, 8)];
      applyStimulus(($urandom_range(0, 299) == 0),
                    3'($urandom_range(0, 7)), a, $urandom(),
                    {$urandom() & 32'hFFFF_FFFC}, ($urandom_range(0, 2) == 0),
                    $urandom(), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    #1;
    applyStimulus(0, 3'd0, 12'h300, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #5;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, 0 expected", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
